// File: rtl/mem_axi_master.sv
// rtl/mem_axi_master.sv - single-outstanding CPU load/store to AXI4-Lite master bridge
// One request at a time; completion is signalled with a one-cycle rsp_valid pulse.
module mem_axi_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_error,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

   state_t                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
   logic                      write_q, write_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                      rsp_error_q, rsp_error_d;
   logic                      aw_hs, w_hs, resp_fire;

   assign req_ready = (state_q == IDLE);
   assign awvalid   = (state_q == WADDR) && !aw_done_q;
   assign wvalid    = (state_q == WADDR) && !w_done_q;
   assign bready    = (state_q == WRESP);
   assign arvalid   = (state_q == RADDR);
   // rready is already high while the read address is in flight
   assign rready    = (state_q == RADDR) || (state_q == RDATA);
   assign rsp_valid = (state_q == DONE);
   assign awaddr    = addr_q;
   assign araddr    = addr_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

   assign aw_hs     = awvalid && awready;
   assign w_hs      = wvalid && wready;
   assign resp_fire = ((state_q == WRESP) && bvalid) || ((state_q == RDATA) && rvalid);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      write_d     = write_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               write_d = req_write;
               state_d = req_write ? WADDR : RADDR;
            end
         end
         WADDR: begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WRESP;
            end
         end
         RADDR: begin
            if (arready) state_d = RDATA;
         end
         WRESP, RDATA: begin
            if (resp_fire) begin
               rsp_rdata_d = write_q ? '0 : rdata;
               rsp_error_d = write_q ? (bresp != RESP_OKAY) : (rresp != RESP_OKAY);
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         write_q     <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         write_q     <= write_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

endmodule

// File: tb/tb_mem_axi_master.sv
// tb/tb_mem_axi_master.sv - scoreboard bench for mem_axi_master with a delay-configurable AXI slave
// Latencies are counted in clock edges from the acceptance edge to the edge that samples rsp_valid.
module tb_mem_axi_master;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, arvalid, bready, rready;
   logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = '0;

   mem_axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0, n_bad = 0;
   int   last_acc = 0;

   // slave configuration and observations
   int          aw_dly = 0, w_dly = 0, ar_dly = 0;
   int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   bit          b_hold = 0, rd_fixed_en = 1;
   logic [31:0] rd_fixed = 32'hDEADBEEF;
   bit          b_pend = 0, r_pend = 0, aw_got = 0, w_got = 0;
   int          aw_hs_n, w_hs_n, ar_hs_n, awv_n, wv_n, aw_hs_cyc, w_hs_cyc;
   logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
   logic [3:0]  seen_wstrb;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr_stats();
      aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; awv_n = 0; wv_n = 0;
      aw_hs_cyc = -1; w_hs_cyc = -1;
      seen_awaddr = '0; seen_wdata = '0; seen_araddr = '0; seen_wstrb = '0;
   endtask

   // AXI slave: handshakes decided at the falling edge, taken at the next rising edge
   initial forever begin
      @(negedge aclk);
      if (!aresetn) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         b_pend = 0; r_pend = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
         bvalid = b_pend && !b_hold;
         bresp  = bresp_cfg;
         if (bvalid && bready) b_pend = 0;
         rvalid = r_pend;
         rresp  = rresp_cfg;
         rdata  = rd_fixed_en ? rd_fixed : ~seen_araddr;
         if (rvalid && rready) r_pend = 0;
         awready = 0;
         if (awvalid) begin
            awv_n++;
            if (aw_cnt >= aw_dly) begin
               awready = 1; aw_cnt = 0; aw_hs_n++; aw_hs_cyc = cyc; seen_awaddr = awaddr; aw_got = 1;
            end else aw_cnt++;
         end
         wready = 0;
         if (wvalid) begin
            wv_n++;
            if (w_cnt >= w_dly) begin
               wready = 1; w_cnt = 0; w_hs_n++; w_hs_cyc = cyc;
               seen_wdata = wdata; seen_wstrb = wstrb; w_got = 1;
            end else w_cnt++;
         end
         if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
         arready = 0;
         if (arvalid) begin
            if (ar_cnt >= ar_dly) begin
               arready = 1; ar_cnt = 0; ar_hs_n++; seen_araddr = araddr; r_pend = 1;
            end else ar_cnt++;
         end
      end
   end

   // response monitor: pops the scoreboard on every completion pulse
   initial forever begin
      @(negedge aclk);
      if (aresetn && rsp_valid) begin
         if (sb.size() == 0) chk("unexpected_rsp_valid", 1, 0);
         else begin
            mon_e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.data);
            chk("rsp_error", rsp_error, mon_e.err);
            chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
         end
      end
      if (aresetn && arvalid) chk("rready_in_raddr", rready, 1);
   end

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] ed, input logic ee,
                        input int lat, input bit push, input bit hold);
      int   budget;
      exp_t ne;
      budget = 0;
      req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st; req_valid = 1;
      while (!req_ready && budget < 100) begin
         @(negedge aclk);
         budget++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 0, 1);
         req_valid = 0;
         return;
      end
      last_acc = cyc;
      if (push) begin
         ne.data = ed; ne.err = ee; ne.acc = cyc; ne.lat = lat;
         sb.push_back(ne);
      end
      @(negedge aclk);
      if (!hold) req_valid = 0;
   endtask

   task automatic wait_done();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 200) begin
         @(negedge aclk);
         b++;
      end
      if (sb.size() != 0) begin
         chk("completion_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge aclk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, rel, b;
      clr_stats();
      repeat (3) @(negedge aclk);
      chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_error}, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_req_regs", {awaddr, wdata}, 0);
      aresetn = 1;
      #1 chk("ready_after_reset", req_ready, 1);
      @(negedge aclk);

      // zero-wait store
      clr_stats();
      issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 3, 1, 0);
      wait_done();
      chk("store_awaddr", seen_awaddr, 32'h10);
      chk("store_wdata", seen_wdata, 32'hDEADBEEF);
      chk("store_wstrb", seen_wstrb, 4'hF);
      chk("store_aw_hs_time", aw_hs_cyc - last_acc, 1);
      chk("store_w_hs_time", w_hs_cyc - last_acc, 1);
      chk("store_hs_counts", {aw_hs_n[7:0], w_hs_n[7:0]}, 16'h0101);

      // zero-wait load
      clr_stats();
      issue(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 1, 0);
      wait_done();
      chk("load_araddr", seen_araddr, 32'h10);
      chk("load_ar_hs_n", ar_hs_n, 1);

      // awready delayed two cycles, wready immediate
      clr_stats();
      aw_dly = 2;
      issue(1, 32'h20, 32'h12345678, 4'h3, 32'h0, 0, 5, 1, 0);
      wait_done();
      aw_dly = 0;
      chk("awvalid_cycles", awv_n, 3);
      chk("wvalid_cycles", wv_n, 1);
      chk("aw_delay_hs_counts", {aw_hs_n[7:0], w_hs_n[7:0]}, 16'h0101);
      chk("aw_delay_wstrb", seen_wstrb, 4'h3);

      // wready delayed three cycles, awready immediate
      clr_stats();
      w_dly = 3;
      issue(1, 32'h24, 32'h0BADF00D, 4'hC, 32'h0, 0, 6, 1, 0);
      wait_done();
      w_dly = 0;
      chk("w_delay_awvalid_cycles", awv_n, 1);
      chk("w_delay_wvalid_cycles", wv_n, 4);

      // arready delayed two cycles
      clr_stats();
      ar_dly = 2; rd_fixed = 32'h01020304;
      issue(0, 32'h30, 32'h0, 4'h0, 32'h01020304, 0, 5, 1, 0);
      wait_done();
      ar_dly = 0;
      chk("ar_delay_ar_hs_n", ar_hs_n, 1);

      // error responses
      rresp_cfg = 2'b10; rd_fixed = 32'hCAFEF00D;
      issue(0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1, 3, 1, 0);
      wait_done();
      rresp_cfg = 2'b00; bresp_cfg = 2'b11;
      issue(1, 32'h44, 32'h55AA55AA, 4'hF, 32'h0, 1, 3, 1, 0);
      wait_done();
      bresp_cfg = 2'b00; rd_fixed = 32'hDEADBEEF;

      // reset while waiting for the write response
      b_hold = 1;
      issue(1, 32'h80, 32'h11112222, 4'hF, 32'h0, 0, 0, 0, 0);
      b = 0;
      while (!bready && b < 50) begin
         @(negedge aclk);
         b++;
      end
      chk("reached_wresp", bready, 1);
      #2 aresetn = 0;
      #1 chk("async_reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      b_hold = 0;
      repeat (2) @(negedge aclk);
      aresetn = 1;
      rel = cyc;
      issue(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 1, 0);
      chk("accept_after_reset", last_acc - rel, 0);
      wait_done();

      // three loads with req_valid held high
      rd_fixed_en = 0;
      issue(0, 32'h100, 32'h0, 4'h0, 32'hFFFFFEFF, 0, 3, 1, 1);
      a0 = last_acc;
      issue(0, 32'h104, 32'h0, 4'h0, 32'hFFFFFEFB, 0, 3, 1, 1);
      chk("b2b_gap_1", last_acc - a0, 4);
      a0 = last_acc;
      issue(0, 32'h108, 32'h0, 4'h0, 32'hFFFFFEF7, 0, 3, 1, 0);
      chk("b2b_gap_2", last_acc - a0, 4);
      wait_done();
      chk("rsp_hold_after_done", rsp_rdata, 32'hFFFFFEF7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_axi_master.md
MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the request and AXI address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width; strobe width is DATA_WIDTH/8.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 aclk  in  1  clock; all state changes on its rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  CPU request handshake.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr / req_wdata / req_wstrb  in  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  request address, store data, byte strobes.
REQ-009 rsp_valid  out  1  one-cycle completion pulse; there is no backpressure.
REQ-010 rsp_rdata / rsp_error  out  DATA_WIDTH / 1  load data (0 for stores), 1 = non-OKAY response.
REQ-011 awaddr, awvalid / awready  out, out / in  ADDR_WIDTH, 1 / 1  AXI4-Lite write address channel.
REQ-012 wdata, wstrb, wvalid / wready  out, out, out / in  DATA_WIDTH, DATA_WIDTH/8, 1 / 1  AXI write data channel.
REQ-013 bresp, bvalid / bready  in, in / out  2, 1 / 1  AXI write response channel.
REQ-014 araddr, arvalid / arready  out, out / in  ADDR_WIDTH, 1 / 1  AXI read address channel.
REQ-015 rdata, rresp, rvalid / rready  in, in, in / out  DATA_WIDTH, 2, 1 / 1  AXI read data channel.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, WADDR, WRESP, RADDR, RDATA and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid & req_ready, at most one outstanding.
REQ-018 On acceptance, addr, wdata, wstrb and write SHALL be registered; awaddr, araddr, wdata and wstrb SHALL drive from these registers, stable until their handshake.
REQ-019 Store: IDLE->WADDR; awvalid and wvalid SHALL both be 1 the cycle after acceptance.
REQ-020 In WADDR, each of awvalid and wvalid SHALL drop independently after its own handshake (done flags); WADDR->WRESP when both are done, including both in the same cycle.
REQ-021 bready SHALL be 1 only in WRESP; on bvalid, latch rsp_error = (bresp != OKAY) and rsp_rdata = 0, then go to DONE.
REQ-022 Load: IDLE->RADDR; arvalid SHALL be 1 in RADDR until arready, then RADDR->RDATA.
REQ-023 rready SHALL be 1 in both RADDR and RDATA, so that a slave deriving arready from rready cannot deadlock.
REQ-024 In RDATA, on rvalid, latch rsp_rdata = rdata and rsp_error = (rresp != OKAY), then go to DONE.
REQ-025 In DONE, rsp_valid SHALL be 1 for exactly one cycle, then return to IDLE; rsp_rdata/rsp_error SHALL hold until the next completion.
REQ-026 Latency with always-ready zero-wait slave: rsp_valid SHALL assert 3 cycles after the acceptance edge, for both loads and stores; the back-to-back issue rate is one request per 4 cycles.
REQ-027 Stall cycles on any AXI ready/valid SHALL extend the latency 1:1, with no limit and no timeout.
REQ-028 rvalid or bvalid arriving outside RDATA/WRESP SHALL be ignored (not consumed).
REQ-029 req_valid while req_ready = 0 SHALL be ignored; the CPU must hold the request.

Reset
REQ-030 While aresetn = 0: state = IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_error = 0; rsp_rdata and the registered request = 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no rsp_valid; after reset release req_ready SHALL be 1 in the first cycle.
REQ-032 Reset assertion SHALL take effect without a clock edge; release is synchronous to aclk.

Verification
REQ-033 Store 0xDEADBEEF, strobe 0xF, address 0x10 to a zero-wait OKAY slave -> awaddr = 0x10 and wdata = 0xDEADBEEF handshake 1 cycle after acceptance; rsp_valid 3 cycles after acceptance, rsp_error = 0, rsp_rdata = 0.
REQ-034 Load from address 0x10, slave returns 0xDEADBEEF -> rready = 1 in RADDR; rsp_valid 3 cycles after acceptance with rsp_rdata = 0xDEADBEEF.
REQ-035 Store with awready delayed 2 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, exactly one of each handshake; rsp_valid at acceptance+5.
REQ-036 Load with rresp = SLVERR (2'b10) and store with bresp = DECERR (2'b11) -> rsp_error = 1 for each, and rsp_rdata = rdata for the load.
REQ-037 aresetn pulsed low while in WRESP -> all valids and readies 0 immediately; no rsp_valid; a new load is accepted 1 cycle after release and completes normally.
REQ-038 req_valid held high continuously for 3 loads -> acceptances exactly 4 cycles apart, with 3 rsp_valid pulses in order.
